// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between fetch and data.
// Optional macro ARB_RR_EN: round-robin tie-break; default is data-over-fetch priority.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic              d_dump,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_dump,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Number of WAIT cycles after ISSUE; zero means ISSUE is the last memory cycle.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state_q;
  logic              gnt_data_q;
  logic              wr_q;
  logic [3:0]        cnt_q;
  logic              if_done_q;
  logic              d_done_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic              mem_dump_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              err_q;

  logic              gnt_data_d;
  logic [ADDR_W-1:0] addr_d;
  logic              last_cyc_d;

`ifdef ARB_RR_EN
  logic last_data_q;

  // Round-robin: on a tie the requester that did not win last time goes first.
  always_comb begin
    gnt_data_d = d_req;
    if (if_req && d_req) begin
      gnt_data_d = !last_data_q;
    end
  end
`else
  // Fixed priority: the data stage holds the older instruction, so it wins.
  always_comb begin
    gnt_data_d = 1'b0;
    gnt_data_d = d_req;
  end
`endif

  assign addr_d = gnt_data_d ? d_addr : if_addr;

  assign last_cyc_d =
    ((state_q == S_ISSUE) && (LAT_M1 == 4'd0)) ||
    ((state_q == S_WAIT) && (cnt_q == 4'd1));

  // Access sequencer with registered memory strobes, done pulses and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_data_q  <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= 4'd0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dump_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
`ifdef ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dump_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;

      unique case (state_q)
        S_IDLE: begin
          if (if_req || d_req) begin
            gnt_data_q  <= gnt_data_d;
            wr_q        <= gnt_data_d && d_wr;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= addr_d;
            mem_wr_q    <= gnt_data_d && d_wr;
            mem_dump_q  <= gnt_data_d && d_dump;
            mem_wdata_q <= gnt_data_d ? d_wdata : '0;
            if (addr_d[0]) begin
              err_q <= 1'b1;
            end
`ifdef ARB_RR_EN
            last_data_q <= gnt_data_d;
`endif
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (last_cyc_d) begin
            state_q <= S_RESP;
          end else begin
            cnt_q   <= LAT_M1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (last_cyc_d) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (last_cyc_d) begin
        if (gnt_data_q) begin
          d_done_q <= 1'b1;
          if (!wr_q) begin
            d_rdata_q <= mem_rdata;
          end
        end else begin
          if_done_q <= 1'b1;
          if_data_q <= mem_rdata;
        end
      end
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_dump  = mem_dump_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (LATENCY 1 and 4) against behavioural memories
// and a transaction-level reference of memory contents, grants and flags.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        if_req [2];
  logic [15:0] if_addr [2];
  logic        if_done [2];
  logic [15:0] if_data [2];
  logic        d_req [2];
  logic        d_wr [2];
  logic        d_dump [2];
  logic [15:0] d_addr [2];
  logic [15:0] d_wdata [2];
  logic        d_done [2];
  logic [15:0] d_rdata [2];
  logic        mem_en [2];
  logic        mem_wr [2];
  logic        mem_dump [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic        err [2];

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] rm [2][256];
  logic [15:0] ifd_exp [2];
  logic [15:0] drd_exp [2];
  bit          err_exp [2];
  bit          lastg_data [2];

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  function automatic logic [15:0] init_val(int a);
    return 16'(a * 935) ^ 16'h5C3A;
  endfunction

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : 4;
    logic [15:0] mem [256];
    logic [15:0] la = '0;
    int          age = 0;
    int          cur_age;
    logic [15:0] ca;
    logic [15:0] rdata;

    initial begin
      for (int k = 0; k < 256; k++) mem[k] = init_val(k);
    end

    always @(posedge clk) begin
      if (mem_en[g]) begin
        la  <= mem_addr[g];
        age <= 2;
        if (mem_wr[g]) mem[mem_addr[g][7:0]] = mem_wdata[g];
      end else if (age != 0 && age < 100) begin
        age <= age + 1;
      end
    end

    // Read data is only valid on the LATENCY-th cycle after issue.
    always_comb begin
      cur_age = mem_en[g] ? 1 : age;
      ca = mem_en[g] ? mem_addr[g] : la;
      rdata = 16'hA5A5 ^ 16'(cur_age);
      if (cur_age == LAT) rdata = mem[ca[7:0]];
    end

    mem_arbiter #(
      .ADDR_W (16),
      .DATA_W (16),
      .LATENCY(LAT)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_done  (if_done[g]),
      .if_data  (if_data[g]),
      .d_req    (d_req[g]),
      .d_wr     (d_wr[g]),
      .d_dump   (d_dump[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_done   (d_done[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_wr   (mem_wr[g]),
      .mem_dump (mem_dump[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(rdata),
      .err      (err[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    err_exp[i] = 1'b0;
    lastg_data[i] = 1'b0;
    ifd_exp[i] = '0;
    drd_exp[i] = '0;
  endtask

  task automatic model_acc(input int i, input bit dat, input bit wr,
                           input logic [15:0] a, input logic [15:0] wd);
    if (a[0]) err_exp[i] = 1'b1;
    lastg_data[i] = dat;
    if (dat && wr) rm[i][a[7:0]] = wd;
    else if (dat) drd_exp[i] = rm[i][a[7:0]];
    else ifd_exp[i] = rm[i][a[7:0]];
  endtask

  task automatic chk_state(input int i);
    chk("if_data", 64'(if_data[i]), 64'(ifd_exp[i]));
    chk("d_rdata", 64'(d_rdata[i]), 64'(drd_exp[i]));
    chk("err", 64'(err[i]), 64'(err_exp[i]));
  endtask

  task automatic access(input int i, input bit dat, input bit wr,
                        input bit dump, input logic [15:0] a,
                        input logic [15:0] wd);
    int n;
    int nen;
    bit seen;
    @(negedge clk);
    if (dat) begin
      d_req[i] = 1'b1;
      d_wr[i] = wr;
      d_dump[i] = dump;
      d_addr[i] = a;
      d_wdata[i] = wd;
    end else begin
      if_req[i] = 1'b1;
      if_addr[i] = a;
    end
    n = 0;
    nen = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_en[i]) begin
        nen++;
        chk("iss_cycle", 64'(n), 64'd1);
        chk("iss_addr", 64'(mem_addr[i]), 64'(a));
        chk("iss_wr", 64'(mem_wr[i]), 64'(dat && wr));
        chk("iss_dump", 64'(mem_dump[i]), 64'(dat && dump));
        if (dat && wr) chk("iss_wdata", 64'(mem_wdata[i]), 64'(wd));
      end else begin
        chk("idle_mem", 64'({mem_wr[i], mem_dump[i],
                              mem_addr[i], mem_wdata[i]}), 64'd0);
      end
      chk("other_done", 64'(dat ? if_done[i] : d_done[i]), 64'd0);
      seen = dat ? d_done[i] : if_done[i];
    end
    if_req[i] = 1'b0;
    d_req[i] = 1'b0;
    chk("done_lat", seen ? 64'(n) : 64'd999, 64'(lat_of(i) + 1));
    chk("en_count", 64'(nen), 64'd1);
    model_acc(i, dat, wr, a, wd);
    chk_state(i);
  endtask

  task automatic arb(input int i);
    int t[$];
    logic [15:0] ga[$];
    int n;
    bit ed;
    @(negedge clk);
    if_req[i] = 1'b1;
    if_addr[i] = 16'h0100;
    d_req[i] = 1'b1;
    d_wr[i] = 1'b0;
    d_dump[i] = 1'b0;
    d_addr[i] = 16'h0200;
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (mem_en[i]) begin
        t.push_back(n);
        ga.push_back(mem_addr[i]);
      end
      if (ga.size() == 4 && (if_done[i] || d_done[i])) break;
    end
    if_req[i] = 1'b0;
    d_req[i] = 1'b0;
    chk("arb_count", 64'(ga.size()), 64'd4);
    for (int k = 0; k < ga.size(); k++) begin
      ed = RR ? !lastg_data[i] : 1'b1;
      chk("arb_grant", 64'(ga[k]), ed ? 64'h200 : 64'h100);
      model_acc(i, ed, 1'b0, ed ? 16'h0200 : 16'h0100, 16'h0);
      if (k == 0) chk("arb_first", 64'(t[k]), 64'd1);
      else chk("arb_rate", 64'(t[k] - t[k-1]), 64'(lat_of(i) + 2));
    end
    chk_state(i);
  endtask

  task automatic reset_mid(input int i);
    int cnt;
    @(negedge clk);
    d_req[i] = 1'b1;
    d_wr[i] = 1'b0;
    d_dump[i] = 1'b0;
    d_addr[i] = 16'h0031;
    repeat (2) @(negedge clk);
    rst[i] = 1'b1;
    @(negedge clk);
    chk("rmid_quiet", 64'({mem_en[i], if_done[i], d_done[i], err[i]}), 64'd0);
    rst[i] = 1'b0;
    d_req[i] = 1'b0;
    model_reset(i);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_done[i] || if_done[i] || mem_en[i]) cnt++;
    end
    chk("rmid_nodone", 64'(cnt), 64'd0);
    chk_state(i);
  endtask

  initial begin
    bit seen [2];
    int kind;
    logic [15:0] a;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) rm[i][k] = init_val(k);
      model_reset(i);
      rst[i] = 1'b1;
      if_req[i] = 1'b1;
      if_addr[i] = 16'h0010;
      d_req[i] = 1'b1;
      d_wr[i] = 1'b0;
      d_dump[i] = 1'b0;
      d_addr[i] = 16'h0040;
      d_wdata[i] = 16'h0;
      seen[i] = 1'b0;
    end

    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("rst_ctl", 64'({if_done[i], d_done[i], mem_en[i], mem_wr[i],
                             mem_dump[i], err[i]}), 64'd0);
        chk("rst_data", 64'({if_data[i], d_rdata[i]}), 64'd0);
        chk("rst_mem", 64'({mem_addr[i], mem_wdata[i]}), 64'd0);
      end
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_accept", 64'(mem_en[i]), 64'd1);
      chk("rst_acc_addr", 64'(mem_addr[i]), 64'h40);
    end
    for (int n = 2; n < 12; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (d_req[i] && d_done[i]) begin
          if_req[i] = 1'b0;
          d_req[i] = 1'b0;
          seen[i] = 1'b1;
          chk("rst_first_lat", 64'(n), 64'(lat_of(i) + 1));
        end
      end
    end
    chk("rst_first_done", 64'({seen[0], seen[1]}), 64'b11);
    for (int i = 0; i < 2; i++) begin
      model_acc(i, 1'b1, 1'b0, 16'h0040, 16'h0);
      chk_state(i);
    end

    access(0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    access(0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
    access(0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);

    arb(0);
    arb(1);

    access(1, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0);
    access(1, 1'b0, 1'b0, 1'b0, 16'h0044, 16'h0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 2; i++) begin
        kind = int'($urandom_range(2, 0));
        a = 16'($urandom) & 16'hFFFE;
        access(i, kind != 0, kind == 2, 1'($urandom),
               a, 16'($urandom));
      end
    end

    reset_mid(1);
    access(1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
    access(1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
    access(0, 1'b0, 1'b0, 1'b0, 16'h0077, 16'h0);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
